// File: rtl/ray_sched_pkg.sv
// Shared types and defaults for the ray column scheduler: FSM state encoding,
// default frame geometry and the Q8.8 pose component type.
package ray_sched_pkg;

    localparam int SCREEN_WIDTH_DEF = 320;
    localparam int HCOUNT_W_DEF     = 9;
    localparam int POSE_W_DEF       = 16;
    localparam int NUM_POSE         = 6;

    typedef logic signed [15:0] pose_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RAY,
        S_DRAIN,
        S_DONE
    } sched_state_t;

endpackage

// File: rtl/ray_column_scheduler_if.sv
// Column handshake between the scheduler (master) and the ray-calc -> DDA
// datapath (slave): issued column index, start pulse, ray handoff and retire pulse.
interface ray_column_scheduler_if #(
    parameter int HCOUNT_W = 9
);
    logic [HCOUNT_W-1:0] hcount_out;
    logic                ray_start_out;
    logic                ray_valid_in;
    logic                dda_ready_in;
    logic                column_done_in;

    modport master (
        output hcount_out, ray_start_out,
        input  ray_valid_in, dda_ready_in, column_done_in
    );

    modport slave (
        input  hcount_out, ray_start_out,
        output ray_valid_in, dda_ready_in, column_done_in
    );
endinterface

// File: rtl/ray_column_scheduler_column_done_tracker.sv
// Saturating count of columns retired by the DDA in the current frame;
// all_done rises once every column has been retired.
module column_done_tracker #(
    parameter int SCREEN_WIDTH = 320,
    parameter int CNT_W        = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic all_done
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (inc && !all_done)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign all_done = (cnt_q == CNT_W'(SCREEN_WIDTH));
endmodule

// File: rtl/ray_column_scheduler.sv
// Frame-level column sequencer: snapshots the camera pose, issues columns to ray
// calc and waits for the DDA to retire them all. RAY_SCHED_OVERRUN_CNT_EN adds a
// saturating count of frame requests dropped while busy.
module ray_column_scheduler
    import ray_sched_pkg::*;
#(
    parameter int SCREEN_WIDTH = SCREEN_WIDTH_DEF,
    parameter int HCOUNT_W     = HCOUNT_W_DEF,
    parameter int POSE_W       = POSE_W_DEF
) (
    input  logic                     pixel_clk_in,
    input  logic                     rst_n_in,
    input  logic                     frame_start_in,
    input  logic signed [POSE_W-1:0] posX_in,
    input  logic signed [POSE_W-1:0] posY_in,
    input  logic signed [POSE_W-1:0] dirX_in,
    input  logic signed [POSE_W-1:0] dirY_in,
    input  logic signed [POSE_W-1:0] planeX_in,
    input  logic signed [POSE_W-1:0] planeY_in,
    output logic signed [POSE_W-1:0] posX_out,
    output logic signed [POSE_W-1:0] posY_out,
    output logic signed [POSE_W-1:0] dirX_out,
    output logic signed [POSE_W-1:0] dirY_out,
    output logic signed [POSE_W-1:0] planeX_out,
    output logic signed [POSE_W-1:0] planeY_out,
    output logic                     frame_busy_out,
    output logic                     frame_done_out,
`ifdef RAY_SCHED_OVERRUN_CNT_EN
    output logic [7:0]               overrun_cnt_out,
`endif
    ray_column_scheduler_if.master   ray_bus
);
    sched_state_t                        state_q, state_d;
    logic [HCOUNT_W-1:0]                 hcount_q, hcount_d;
    logic                                ray_start_q, ray_start_d;
    logic                                busy_q, busy_d;
    logic                                done_q, done_d;
    logic [NUM_POSE-1:0][POSE_W-1:0]     pose_q, pose_d;

    logic handoff, last_col, cols_clear, cols_inc, all_done;

    assign handoff  = ray_bus.ray_valid_in & ray_bus.dda_ready_in;
    assign last_col = (hcount_q == HCOUNT_W'(SCREEN_WIDTH - 1));

    // Retire pulses only count while a frame is in flight.
    assign cols_inc = ray_bus.column_done_in &&
                      (state_q == S_ISSUE || state_q == S_WAIT_RAY || state_q == S_DRAIN);

    column_done_tracker #(
        .SCREEN_WIDTH (SCREEN_WIDTH),
        .CNT_W        (HCOUNT_W + 1)
    ) u_cols (
        .clk      (pixel_clk_in),
        .rst_n    (rst_n_in),
        .clear    (cols_clear),
        .inc      (cols_inc),
        .all_done (all_done)
    );

    always_comb begin
        state_d    = state_q;
        hcount_d   = hcount_q;
        pose_d     = pose_q;
        cols_clear = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start_in) begin
                    pose_d     = {planeY_in, planeX_in, dirY_in, dirX_in, posY_in, posX_in};
                    hcount_d   = '0;
                    cols_clear = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE:    state_d = S_WAIT_RAY;
            S_WAIT_RAY: begin
                if (handoff) begin
                    if (last_col) begin
                        state_d = S_DRAIN;
                    end else begin
                        hcount_d = hcount_q + 1'b1;
                        state_d  = S_ISSUE;
                    end
                end
            end
            // Compare uses the registered count, so a same-cycle retire lands a cycle later.
            S_DRAIN:    if (all_done) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        ray_start_d = (state_d == S_ISSUE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_n_in) begin
            state_q     <= S_IDLE;
            hcount_q    <= '0;
            ray_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pose_q      <= '0;
        end else begin
            state_q     <= state_d;
            hcount_q    <= hcount_d;
            ray_start_q <= ray_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pose_q      <= pose_d;
        end
    end

    assign ray_bus.hcount_out    = hcount_q;
    assign ray_bus.ray_start_out = ray_start_q;
    assign frame_busy_out        = busy_q;
    assign frame_done_out        = done_q;
    assign posX_out              = pose_q[0];
    assign posY_out              = pose_q[1];
    assign dirX_out              = pose_q[2];
    assign dirY_out              = pose_q[3];
    assign planeX_out            = pose_q[4];
    assign planeY_out            = pose_q[5];

`ifdef RAY_SCHED_OVERRUN_CNT_EN
    logic [7:0] ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (frame_start_in && state_q != S_IDLE && ovr_q != 8'hFF)
            ovr_d = ovr_q + 8'd1;
    end

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_n_in) ovr_q <= '0;
        else           ovr_q <= ovr_d;
    end

    assign overrun_cnt_out = ovr_q;
`endif
endmodule

// File: tb/tb_ray_column_scheduler.sv
// Scoreboard bench for ray_column_scheduler on a 4-column frame with a modelled
// ray-calc/DDA responder; expected starts and frame completions are queued up front.
module tb_ray_column_scheduler;
    localparam int SW = 4;
    localparam int HW = 2;

    typedef struct packed {
        logic [HW-1:0] hc;
        logic [15:0]   px;
    } exp_start_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fstart = 1'b0;
    logic [15:0] px_i = '0, py_i = '0, dx_i = '0, dy_i = '0, plx_i = '0, ply_i = '0;
    logic [15:0] px_o, py_o, dx_o, dy_o, plx_o, ply_o;
    logic        busy, fdone;
`ifdef RAY_SCHED_OVERRUN_CNT_EN
    logic [7:0]  ovr;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_start_t exp_st[$];
    int         exp_done[$];
    int         cd_q[$];
    bit         auto_cd = 1'b1;
    int         inj_req = 0;
    int         last_cd_cyc = 0;

    ray_column_scheduler_if #(.HCOUNT_W(HW)) rif();

    ray_column_scheduler #(
        .SCREEN_WIDTH (SW),
        .HCOUNT_W     (HW),
        .POSE_W       (16)
    ) dut (
        .pixel_clk_in   (clk),
        .rst_n_in       (rst_n),
        .frame_start_in (fstart),
        .posX_in        (px_i),
        .posY_in        (py_i),
        .dirX_in        (dx_i),
        .dirY_in        (dy_i),
        .planeX_in      (plx_i),
        .planeY_in      (ply_i),
        .posX_out       (px_o),
        .posY_out       (py_o),
        .dirX_out       (dx_o),
        .dirY_out       (dy_o),
        .planeX_out     (plx_o),
        .planeY_out     (ply_o),
        .frame_busy_out (busy),
        .frame_done_out (fdone),
`ifdef RAY_SCHED_OVERRUN_CNT_EN
        .overrun_cnt_out(ovr),
`endif
        .ray_bus        (rif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_frame(input logic [15:0] px, input int done_tag);
        for (int i = 0; i < SW; i++) begin
            exp_start_t e;
            e.hc = HW'(i);
            e.px = px;
            exp_st.push_back(e);
        end
        if (done_tag >= 0) exp_done.push_back(done_tag);
    endtask

    // Monitor: every start and every frame_done must match a queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rif.ray_start_out) begin
                chk("start_expected", exp_st.size() > 0, 1);
                if (exp_st.size() > 0) begin
                    exp_start_t e;
                    e = exp_st.pop_front();
                    chk("start_hcount", rif.hcount_out, e.hc);
                    chk("start_posx", px_o, e.px);
                end
            end
            if (fdone) begin
                chk("done_expected", exp_done.size() > 0, 1);
                if (exp_done.size() > 0) begin
                    int tag;
                    tag = exp_done.pop_front();
                    if (tag == 1) chk("done_latency", cyc - last_cd_cyc, 2);
                end
            end
        end
    end

    // Ray-calc / DDA model: valid 3 cycles after start, retire 5 cycles after handoff.
    initial begin
        bit            ray_pend = 1'b0;
        int            ray_due = 0;
        int            inj_done = 0;
        logic [HW-1:0] start_hc = '0;
        rif.ray_valid_in   = 1'b0;
        rif.column_done_in = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rif.ray_valid_in   = 1'b0;
                rif.column_done_in = 1'b0;
                ray_pend           = 1'b0;
                cd_q.delete();
                inj_done           = inj_req;
            end else begin
                if (rif.ray_valid_in && rif.dda_ready_in) begin
                    rif.ray_valid_in = 1'b0;
                    if (auto_cd) cd_q.push_back(cyc + 5);
                    if (start_hc != HW'(SW - 1)) chk("handoff_next_start", rif.ray_start_out, 1);
                end
                if (rif.ray_start_out) begin
                    ray_pend = 1'b1;
                    ray_due  = cyc + 3;
                    start_hc = rif.hcount_out;
                end
                if (ray_pend && cyc >= ray_due) begin
                    rif.ray_valid_in = 1'b1;
                    ray_pend         = 1'b0;
                end
                rif.column_done_in = 1'b0;
                if (inj_done < inj_req) begin
                    rif.column_done_in = 1'b1;
                    inj_done++;
                end else if (cd_q.size() > 0 && cd_q[0] <= cyc) begin
                    rif.column_done_in = 1'b1;
                    void'(cd_q.pop_front());
                    last_cd_cyc = cyc;
                end
            end
        end
    end

    task automatic wait_start_hc(input logic [HW-1:0] hc, input int budget);
        int n = 0;
        while (!(rif.ray_start_out && rif.hcount_out == hc) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_start_in_time", n < budget, 1);
    endtask

    task automatic wait_valid(input logic lvl, input int budget);
        int n = 0;
        while (rif.ray_valid_in !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid_in_time", n < budget, 1);
    endtask

    // Waits for frame_done, optionally re-requests during DONE, then checks the IDLE cycle.
    task automatic wait_done(input int budget, input bit drop);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fdone && n < budget);
        chk("frame_done_seen", fdone, 1);
        if (drop) fstart = 1'b1;
        @(negedge clk);
        fstart = 1'b0;
        chk("busy_after_done", busy, 0);
        chk("no_start_after_done", rif.ray_start_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rif.dda_ready_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_hcount", rif.hcount_out, 0);
        chk("rst_ray_start", rif.ray_start_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", fdone, 0);
        chk("rst_posx", px_o, 0);
        chk("rst_planey", ply_o, 0);
`ifdef RAY_SCHED_OVERRUN_CNT_EN
        chk("rst_overrun", ovr, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Frame 1: nominal, pose change and request at column 2, request during DONE.
        px_i = 16'h0280; py_i = 16'h0100; dx_i = 16'hFF00;
        dy_i = 16'h0000; plx_i = 16'h0000; ply_i = 16'h00A8;
        push_frame(16'h0280, 1);
        fstart = 1'b1;
        @(negedge clk);
        fstart = 1'b0;
        chk("f1_first_start", rif.ray_start_out, 1);
        chk("f1_first_hcount", rif.hcount_out, 0);
        chk("f1_busy", busy, 1);
        chk("f1_dirx", dx_o, 16'hFF00);
        chk("f1_planey", ply_o, 16'h00A8);
        wait_start_hc(2, 40);
        fstart = 1'b1;
        px_i   = 16'h0300;
        @(negedge clk);
        fstart = 1'b0;
        wait_done(100, 1'b1);
        chk("f1_posx_held", px_o, 16'h0280);
`ifdef RAY_SCHED_OVERRUN_CNT_EN
        chk("f1_overrun", ovr, 2);
`endif

        // Frame 2: started in the first IDLE cycle, DDA stalled for 10 cycles on column 0.
        push_frame(16'h0300, 1);
        rif.dda_ready_in = 1'b0;
        fstart = 1'b1;
        @(negedge clk);
        fstart = 1'b0;
        chk("f2_start_first_idle", rif.ray_start_out, 1);
        wait_valid(1'b1, 10);
        repeat (10) begin
            @(negedge clk);
            chk("stall_hcount", rif.hcount_out, 0);
            chk("stall_no_start", rif.ray_start_out, 0);
        end
        chk("stall_busy", busy, 1);
        rif.dda_ready_in = 1'b1;
        wait_done(100, 1'b0);

        // Frame 3: three manual retires, reset while draining the last column.
        auto_cd = 1'b0;
        push_frame(16'h0300, -1);
        fstart = 1'b1;
        @(negedge clk);
        fstart = 1'b0;
        inj_req = inj_req + 3;
        wait_start_hc(3, 60);
        wait_valid(1'b1, 10);
        wait_valid(1'b0, 10);
        @(negedge clk);
        chk("drain_busy", busy, 1);
        chk("drain_no_done", fdone, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_hcount", rif.hcount_out, 0);
        chk("midrst_ray_start", rif.ray_start_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", fdone, 0);
        chk("midrst_posx", px_o, 0);
`ifdef RAY_SCHED_OVERRUN_CNT_EN
        chk("midrst_overrun", ovr, 0);
`endif
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_idle", busy, 0);

        // Frame 4: two extra retire pulses, count must saturate at 4.
        auto_cd = 1'b1;
        px_i = 16'h0400;
        push_frame(16'h0400, 0);
        fstart = 1'b1;
        @(negedge clk);
        fstart = 1'b0;
        inj_req = inj_req + 2;
        wait_done(120, 1'b0);
        repeat (25) @(negedge clk);
        chk("final_idle", busy, 0);
        chk("final_posx", px_o, 16'h0400);
        chk("starts_all_seen", exp_st.size(), 0);
        chk("dones_all_seen", exp_done.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ray_column_scheduler.md
# ray_column_scheduler

Frame-level controller that sequences the ray-calculation datapath across every screen column. On a frame request it snapshots the camera pose and issues column indices 0..SCREEN_WIDTH-1 one at a time. Ray calculation for column n+1 overlaps DDA traversal of column n. The frame is declared complete once the DDA has retired every column. It sits between the player/controller logic and the ray-calc → DDA pipeline.

## Interface
- SCREEN_WIDTH, 320, columns per frame
- HCOUNT_W, 9, column index width; must satisfy 2^HCOUNT_W ≥ SCREEN_WIDTH
- POSE_W, 16, width of each signed Q8.8 pose component
- pixel_clk_in  in  1  sole clock; all logic on its rising edge
- rst_n_in  in  1  synchronous, active-low reset
- frame_start_in  in  1  single-cycle frame render request
- posX_in, posY_in, dirX_in, dirY_in, planeX_in, planeY_in  in  POSE_W each  live camera pose, signed Q8.8
- posX_out … planeY_out  out  POSE_W each  pose snapshot, held constant for the whole frame
- hcount_out  out  HCOUNT_W  column currently issued to ray calc
- ray_start_out  out  1  single-cycle start pulse to ray calc; hcount_out is valid with it
- ray_valid_in  in  1  ray calc result valid; held until handed off
- dda_ready_in  in  1  DDA can accept a ray; handoff = ray_valid_in & dda_ready_in
- column_done_in  in  1  single-cycle pulse; DDA has retired one column
- frame_busy_out  out  1  high in every state except IDLE
- frame_done_out  out  1  single-cycle pulse when all columns are retired

## Operation
- States: IDLE, ISSUE, WAIT_RAY, DRAIN, DONE. All outputs are registered (Moore).
- IDLE, on frame_start_in:
  - latch all six pose inputs into the *_out registers
  - hcount_out ← 0, cols_done ← 0
  - go to ISSUE
- IDLE, frame_start_in low: stay.
- ISSUE: ray_start_out = 1 for exactly this cycle; go to WAIT_RAY unconditionally.
- WAIT_RAY, on handoff:
  - if hcount_out == SCREEN_WIDTH-1 → DRAIN
  - else hcount_out ← hcount_out+1 → ISSUE
- WAIT_RAY, no handoff: hold.
- DRAIN: when cols_done == SCREEN_WIDTH → DONE.
- DONE: frame_done_out = 1 for this cycle; go to IDLE.
- cols_done (HCOUNT_W+1 bits):
  - increments on column_done_in in ISSUE, WAIT_RAY and DRAIN
  - saturates at SCREEN_WIDTH; extra pulses are ignored
  - column_done_in in IDLE or DONE is ignored
- Same-cycle column_done_in and handoff: both take effect.
- Same-cycle column_done_in and the DRAIN compare: the compare uses the registered count, so the transition happens one cycle later.
- frame_start_in while frame_busy_out is high is dropped. The pose snapshot is not disturbed.
- Pose inputs are never sampled outside the IDLE→ISSUE transition.

## Timing
- Reset values: hcount_out 0, ray_start_out 0, frame_busy_out 0, frame_done_out 0, all pose outputs 0, cols_done 0, state IDLE.
- frame_start_in at cycle t → ray_start_out high and hcount_out=0 at t+1.
- Handoff at cycle t → hcount_out incremented and ray_start_out high at t+1. Minimum column period is 2 cycles.
- Last column retired at t → DONE at t+2, frame_done_out high at t+2, IDLE (busy low) at t+3.
- A new frame_start_in is accepted in the first IDLE cycle.
- Reset asserted mid-frame: all state returns to reset values at the next edge. No frame_done_out is produced and the frame is abandoned.

## Configuration
- RAY_SCHED_OVERRUN_CNT_EN defined:
  - adds output overrun_cnt_out [7:0], reset 0
  - increments on every dropped frame_start_in, saturates at 255
  - cleared only by reset
- Undefined: the port and counter are absent; dropped requests leave no trace.

## Structure
- Shared package ray_sched_pkg holds:
  - state enum sched_state_t
  - default SCREEN_WIDTH localparam
  - Q8.8 pose typedef (pose_t, signed [15:0])
- One natural sub-module: column_done_tracker, the saturating cols_done counter with a clear input and an all_done flag. The FSM, pose snapshot and hcount counter stay in the top.

## Test plan
- SCREEN_WIDTH=4, ray_valid_in returned 3 cycles after each start, dda_ready_in=1, column_done_in 5 cycles after each handoff → starts with hcount 0,1,2,3; exactly one frame_done_out; busy low the following cycle.
- Pose input changed from posX_in=0x0280 to 0x0300 mid-frame → posX_out stays 0x0280 until the next frame start.
- dda_ready_in held low 10 cycles while ray_valid_in=1 → hcount_out and state frozen; no extra ray_start_out pulse.
- frame_start_in pulsed at column 2 and during DONE → both dropped; overrun_cnt_out=2 with RAY_SCHED_OVERRUN_CNT_EN.
- rst_n_in low for 1 cycle while in DRAIN with cols_done=3 → all outputs at reset values next cycle; no frame_done_out.
- 6 column_done_in pulses in a 4-column frame → cols_done saturates at 4; single frame_done_out.
